// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-RAM arbiter.
// Requester identities, FSM state encoding and the address legality check.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_e;

  localparam int WORD_BYTES = 4;

  // A byte address is rejected if it is not word aligned or lies beyond the RAM.
  function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr & (WORD_BYTES - 1)) != 32'd0;
    out_of_range = (addr >> (addr_w + 2)) != 32'd0;
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 is fetch, bit 1 is the loader.
// On contention the requester that was not granted last wins.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OWN_LOAD) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between instruction fetch and the loader,
// one access at a time, with registered responses and error replies for bad addresses.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [31:0]       f_req_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic [31:0]       l_req_addr,
  input  logic              l_req_we,
  input  logic [31:0]       l_req_wdata,
  output logic              l_rsp_valid,
  input  logic              l_rsp_ready,
  output logic [31:0]       l_rsp_data,
  output logic              l_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]  state;
  owner_e      owner;
  owner_e      last_grant;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_is_write;

  logic        idle;
  logic [1:0]  req_valid;
  logic [1:0]  grant;
  logic        sel_load;
  logic [31:0] sel_addr;
  logic        addr_err;
  logic        take;
  logic        legal_take;
  logic        owner_rsp_ready;

  // Requests are only sampled in IDLE, and never while reset is held.
  assign idle      = (state == S_IDLE) && !reset;
  assign req_valid = idle ? {l_req_valid, f_req_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_load   = grant[1];
  assign sel_addr   = sel_load ? l_req_addr : f_req_addr;
  assign addr_err   = addr_bad(sel_addr, ADDR_W);
  assign take       = |grant;
  assign legal_take = take && !addr_err;

  assign f_req_ready = grant[0];
  assign l_req_ready = grant[1];

  // RAM strobes are driven only in a legal grant cycle and held at zero otherwise.
  assign mem_en    = legal_take;
  assign mem_we    = legal_take && sel_load && l_req_we;
  assign mem_addr  = legal_take ? sel_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = (legal_take && sel_load) ? l_req_wdata : 32'd0;

  assign f_rsp_valid = (state == S_RESP) && (owner == OWN_FETCH);
  assign l_rsp_valid = (state == S_RESP) && (owner == OWN_LOAD);
  assign f_rsp_data  = rsp_data;
  assign l_rsp_data  = rsp_data;
  assign f_rsp_err   = rsp_err;
  assign l_rsp_err   = rsp_err;

  assign owner_rsp_ready = (owner == OWN_LOAD) ? l_rsp_ready : f_rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      owner        <= OWN_FETCH;
      last_grant   <= OWN_LOAD;
      rsp_data     <= 32'd0;
      rsp_err      <= 1'b0;
      rsp_is_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            owner      <= sel_load ? OWN_LOAD : OWN_FETCH;
            last_grant <= sel_load ? OWN_LOAD : OWN_FETCH;
            if (addr_err) begin
              rsp_data <= 32'd0;
              rsp_err  <= 1'b1;
              state    <= S_RESP;
            end else begin
              rsp_is_write <= mem_we;
              state        <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          rsp_data <= rsp_is_write ? 32'd0 : mem_rdata;
          rsp_err  <= 1'b0;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (owner_rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port synchronous instruction RAM between two requesters: the core's instruction fetch (read-only) and the program loader/debug port (read/write). It arbitrates round-robin and issues one access at a time to the RAM. It returns registered responses with valid/ready handshakes and rejects misaligned or out-of-range addresses with an error response, without touching the RAM. It sits between the fetch stage, the loader, and the writable replacement for the fixed instruction ROM.

## Interface
- ADDR_W, 10, RAM word-address width (depth = 2**ADDR_W words)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  32  fetch byte address (pc)
- f_rsp_valid  out  1  fetch response valid
- f_rsp_ready  in  1  fetch consumer accepts response
- f_rsp_data  out  32  instruction word
- f_rsp_err  out  1  misaligned/out-of-range
- l_req_valid, l_req_ready, l_req_addr  in/out/in  1/1/32  loader request, as fetch
- l_req_we  in  1  1 = write
- l_req_wdata  in  32  write data
- l_rsp_valid, l_rsp_ready, l_rsp_data, l_rsp_err  out/in/out/out  1/1/32/1  loader response, as fetch
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word index
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: pick a requester. If only one is valid, pick it. If both are valid, pick the one not granted last. last_grant resets to loader, so fetch wins the first contention. The selected req_ready = 1 combinationally; the other = 0.
- Address check on grant: addr[1:0] != 0, or addr[31:ADDR_W+2] != 0 → error. No mem_en. Response reg ← data 0, err 1. Next state RESP.
- Legal grant: mem_en = 1, mem_addr = addr[ADDR_W+1:2]. mem_we = l_req_we for the loader, 0 for fetch. mem_wdata = l_req_wdata. Next state ACCESS. Record the owner; update last_grant.
- ACCESS: capture mem_rdata into the response reg for a read, or 0 for a write; err 0. Next state RESP.
- RESP: the owner's rsp_valid = 1, holding data and err stable. On rsp_ready → IDLE. Both req_ready = 0.
- The non-owner's rsp_valid is always 0. mem_en = 0 outside the IDLE grant cycle.

## Timing
- Reset values: f/l_req_ready 0, f/l_rsp_valid 0, rsp_data 0, rsp_err 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset asserted in any state: next cycle IDLE. Any pending response is discarded. mem_en is 0 during the reset cycle.
- Legal request handshake at cycle T → RAM access at T → rsp_valid from T+2.
- Error request handshake at T → rsp_valid from T+1.
- Minimum issue interval: 3 cycles legal, 2 cycles error, with rsp_ready held high.
- Backpressure: rsp_valid stays high indefinitely while rsp_ready = 0. No new grant is made in that time.
- A requester may drop req_valid without a handshake. Only the IDLE-cycle valid is sampled.
- Write then read of the same address (either requester) returns the new data. Accesses are strictly sequential.

## Structure
- Shared package imem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_FETCH, OWN_LOAD}
  - constant WORD_BYTES = 4
- One sub-module: rr_arb2. Two-way round-robin picker: valid[1:0] and last_grant in, one-hot grant out, purely combinational. The last_grant register lives in imem_arbiter.

## Test plan
- Fetch only, read at 0x0000 with RAM word 0xFFC4A303 preloaded → f_rsp_valid at T+2, data 0xFFC4A303, err 0.
- Loader writes 0x0062E233 to 0x0008, then fetch reads 0x0008 → fetch data 0x0062E233. Loader response has data 0 and err 0.
- Both valid every cycle for 6 grants → grants alternate fetch, loader, fetch…, starting with fetch after reset.
- Fetch 0x0006 (misaligned) and fetch 0x0000_1000 with ADDR_W=10 (out of range) → err 1 and data 0 at T+1. mem_en never asserted.
- f_rsp_ready held low 5 cycles with loader valid → f_rsp_valid and data stable and l_req_ready 0 throughout. Loader is granted the cycle after the fetch response is accepted.
- Reset asserted in ACCESS → next cycle all outputs at reset values and no response emitted. The next request completes normally.
